// File: rtl/sgbm_pkg.sv
// Shared SGBM constants and types, used by disparity_calc and the disparity post-filters.
// Frame geometry defaults and word widths live here so every stage agrees on them.
package sgbm_pkg;

   localparam int IMAGE_ROW = 200;
   localparam int IMAGE_COL = 400;
   localparam int DATA_W    = 32;
   localparam int COORD_W   = 10;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      RUN      = 1'b1
   } med_state_t;

endpackage

// File: rtl/median3_sort.sv
// Combinational 3-input unsigned sorter: returns min, median and max.
// Used for the row sorts and for both reduction stages of the median-of-9 network.
module median3_sort #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] mn,
   output logic [W-1:0] md,
   output logic [W-1:0] mx
);

   logic [W-1:0] lo_ab;
   logic [W-1:0] hi_ab;

   assign lo_ab = (a < b) ? a : b;
   assign hi_ab = (a < b) ? b : a;

   assign mn = (lo_ab < c) ? lo_ab : c;
   assign mx = (hi_ab > c) ? hi_ab : c;
   // With lo_ab <= hi_ab known, the median is c clamped into [lo_ab, hi_ab].
   assign md = (hi_ab < c) ? hi_ab : ((lo_ab > c) ? lo_ab : c);

endmodule

// File: rtl/disparity_median3x3.sv
// Streaming 3x3 median filter on the disparity_calc output stream.
// Two line buffers feed a 3x3 window; a 3-stage sort network yields interior-pixel medians.
module disparity_median3x3 #(
   parameter int IMAGE_ROW = sgbm_pkg::IMAGE_ROW,
   parameter int IMAGE_COL = sgbm_pkg::IMAGE_COL,
   parameter int DATA_W    = sgbm_pkg::DATA_W,
   parameter int COORD_W   = sgbm_pkg::COORD_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [DATA_W-1:0]  disparity_in,
   input  logic [COORD_W-1:0] row_in,
   input  logic [COORD_W-1:0] col_in,
   output logic [DATA_W-1:0]  disparity_out,
   output logic [COORD_W-1:0] row_out,
   output logic [COORD_W-1:0] col_out,
   output logic               valid,
   output logic               frame_done
);

   import sgbm_pkg::*;

   localparam int ADDR_W = $clog2(IMAGE_COL);

   typedef struct packed {
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] col;
      logic               done;
   } meta_t;

   med_state_t        state;
   logic              accept;
   logic              last_px;
   logic              emit;
   logic [ADDR_W-1:0] addr;

   logic [DATA_W-1:0] lb0 [IMAGE_COL];
   logic [DATA_W-1:0] lb1 [IMAGE_COL];
   logic [DATA_W-1:0] win [3][3];   // [row][col]: row 2 is the current line, col 2 the newest pixel

   logic [3:0]        vld;
   meta_t             meta [4];

   assign addr    = col_in[ADDR_W-1:0];
   assign last_px = (row_in == COORD_W'(IMAGE_ROW - 1)) && (col_in == COORD_W'(IMAGE_COL - 1));
   assign accept  = rst && en && ((state == RUN) || (row_in == '0 && col_in == '0));
   assign emit    = accept && (row_in >= COORD_W'(2)) && (col_in >= COORD_W'(2));

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= WAIT_SOF;
         vld   <= '0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
      end else begin
         vld <= {vld[2:0], emit};
         if (accept) begin
            state <= last_px ? WAIT_SOF : RUN;
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0[addr];
            win[1][2] <= lb1[addr];
            win[2][2] <= disparity_in;
         end
      end
   end

   // NOTE: line buffers are plain RAM with no reset; stale lines are never used because output waits for a fresh frame start.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[addr] <= disparity_in;
         lb0[addr] <= lb1[addr];
      end
   end

   // Coordinates travel alongside the data; the frame_done centre is reached exactly on the last input pixel.
   always_ff @(posedge clk) begin
      meta[0] <= '{row: row_in - COORD_W'(1), col: col_in - COORD_W'(1), done: last_px};
      for (int i = 1; i < 4; i++) begin
         meta[i] <= meta[i-1];
      end
   end

   // S1: sort each window row.
   logic [DATA_W-1:0] row_mn [3];
   logic [DATA_W-1:0] row_md [3];
   logic [DATA_W-1:0] row_mx [3];
   logic [DATA_W-1:0] s1_mn  [3];
   logic [DATA_W-1:0] s1_md  [3];
   logic [DATA_W-1:0] s1_mx  [3];

   for (genvar r = 0; r < 3; r++) begin : g_row_sort
      median3_sort #(.W(DATA_W)) u_sort (
         .a  (win[r][0]),
         .b  (win[r][1]),
         .c  (win[r][2]),
         .mn (row_mn[r]),
         .md (row_md[r]),
         .mx (row_mx[r])
      );
   end

   always_ff @(posedge clk) begin
      s1_mn <= row_mn;
      s1_md <= row_md;
      s1_mx <= row_mx;
   end

   // S2: max of minima, median of medians, min of maxima.
   logic [DATA_W-1:0] lo_max, md_med, hi_min;
   logic [DATA_W-1:0] s2_lo, s2_md, s2_hi;
   logic [DATA_W-1:0] unused_lo_mn, unused_lo_md;
   logic [DATA_W-1:0] unused_md_mn, unused_md_mx;
   logic [DATA_W-1:0] unused_hi_md, unused_hi_mx;

   median3_sort #(.W(DATA_W)) u_lo_sort (
      .a(s1_mn[0]), .b(s1_mn[1]), .c(s1_mn[2]),
      .mn(unused_lo_mn), .md(unused_lo_md), .mx(lo_max)
   );
   median3_sort #(.W(DATA_W)) u_md_sort (
      .a(s1_md[0]), .b(s1_md[1]), .c(s1_md[2]),
      .mn(unused_md_mn), .md(md_med), .mx(unused_md_mx)
   );
   median3_sort #(.W(DATA_W)) u_hi_sort (
      .a(s1_mx[0]), .b(s1_mx[1]), .c(s1_mx[2]),
      .mn(hi_min), .md(unused_hi_md), .mx(unused_hi_mx)
   );

   always_ff @(posedge clk) begin
      s2_lo <= lo_max;
      s2_md <= md_med;
      s2_hi <= hi_min;
   end

   // S3: median of the three survivors is the median of all nine.
   logic [DATA_W-1:0] med9, s3_med;
   logic [DATA_W-1:0] unused_s3_mn, unused_s3_mx;

   median3_sort #(.W(DATA_W)) u_final_sort (
      .a(s2_lo), .b(s2_md), .c(s2_hi),
      .mn(unused_s3_mn), .md(med9), .mx(unused_s3_mx)
   );

   always_ff @(posedge clk) begin
      s3_med <= med9;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         disparity_out <= '0;
         row_out       <= '0;
         col_out       <= '0;
         valid         <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         valid      <= vld[3];
         frame_done <= vld[3] && meta[3].done;
         if (vld[3]) begin
            disparity_out <= s3_med;
            row_out       <= meta[3].row;
            col_out       <= meta[3].col;
         end
      end
   end

endmodule

// File: tb/tb_disparity_median3x3.sv
// Randomized self-checking bench for disparity_median3x3 on a reduced frame size.
// A frame-image reference model computes each interior median by sorting its nine neighbours.
module tb_disparity_median3x3;

   localparam int IR    = 12;
   localparam int IC    = 16;
   localparam int DW    = 32;
   localparam int CW    = 10;
   localparam int N_OUT = (IR - 2) * (IC - 2);

   logic          clk;
   logic          rst;
   logic          en;
   logic [DW-1:0] disparity_in;
   logic [CW-1:0] row_in;
   logic [CW-1:0] col_in;
   logic [DW-1:0] disparity_out;
   logic [CW-1:0] row_out;
   logic [CW-1:0] col_out;
   logic          valid;
   logic          frame_done;

   disparity_median3x3 #(
      .IMAGE_ROW(IR), .IMAGE_COL(IC), .DATA_W(DW), .COORD_W(CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .disparity_in  (disparity_in),
      .row_in        (row_in),
      .col_in        (col_in),
      .disparity_out (disparity_out),
      .row_out       (row_out),
      .col_out       (col_out),
      .valid         (valid),
      .frame_done    (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int          due;
      logic [31:0] val;
      int          r;
      int          c;
      bit          done;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] img [IR][IC];
   int          cyc       = 0;
   bit          was_reset = 1'b0;
   int          n_valid   = 0;
   int          n_done    = 0;
   int          cur_gap   = 1;

   // Reference model at each rising edge, output comparison at each falling edge.
   always begin : model
      bit          in_frame;
      int          r, c;
      logic [31:0] nb[$];
      exp_t        e;
      logic [31:0] last_val;
      int          last_r, last_c;
      bit          have_prev;
      int          prev_vrow, prev_vcyc;

      in_frame = 1'b0;
      last_val = '0; last_r = 0; last_c = 0;
      have_prev = 1'b0; prev_vrow = 0; prev_vcyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
         was_reset = !rst;
         if (!rst) begin
            in_frame = 1'b0;
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due >= cyc) void'(exp_q.pop_back());
         end else if (en && (in_frame || (row_in == 0 && col_in == 0))) begin
            r = int'(row_in);
            c = int'(col_in);
            in_frame = !(r == IR - 1 && c == IC - 1);
            img[r][c] = disparity_in;
            if (r >= 2 && c >= 2) begin
               nb.delete();
               for (int dr = -2; dr <= 0; dr++)
                  for (int dc = -2; dc <= 0; dc++)
                     nb.push_back(img[r+dr][c+dc]);
               nb.sort();
               exp_q.push_back('{due: cyc + 4, val: nb[4], r: r - 1, c: c - 1,
                                 done: (r == IR - 1 && c == IC - 1)});
            end
         end

         @(negedge clk);
         if (was_reset) begin
            last_val = '0; last_r = 0; last_c = 0;
            have_prev = 1'b0;
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("valid", valid, 1);
            check("data", disparity_out, e.val);
            check("row", row_out, e.r);
            check("col", col_out, e.c);
            check("frame_done", frame_done, e.done);
            last_val = e.val; last_r = e.r; last_c = e.c;
         end else begin
            check("valid_idle", valid, 0);
            check("done_idle", frame_done, 0);
            check("hold_data", disparity_out, last_val);
            check("hold_row", row_out, last_r);
            check("hold_col", col_out, last_c);
         end
         if (valid) begin
            n_valid++;
            if (frame_done) n_done++;
            if (have_prev && int'(row_out) == prev_vrow)
               check("spacing", cyc - prev_vcyc, cur_gap);
            have_prev = 1'b1;
            prev_vrow = int'(row_out);
            prev_vcyc = cyc;
         end
      end
   end

   function automatic logic [31:0] pix(input int kind, input int r, input int c);
      case (kind)
         0:       return 32'h0000_0005;
         1:       return (r == 5 && c == 6) ? 32'hFFFF_FFFF : 32'h0000_0010;
         2:       return 32'(r * IC + c);
         3:       return $urandom;
         4:       return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0000_0001;
         5:       return ((r == 3 || r == 5) && (c == 3 || c == 5)) ? 32'h0000_0001 : 32'h8000_0000;
         default: return 32'($urandom_range(0, 3));
      endcase
   endfunction

   // Drive the raster span [(r0,c0) .. (r1,c1)], one pixel every gap cycles.
   task automatic send_span(input int kind, input int r0, input int c0,
                            input int r1, input int c1, input int gap);
      for (int idx = r0 * IC + c0; idx <= r1 * IC + c1; idx++) begin
         @(negedge clk);
         en           = 1'b1;
         row_in       = CW'(idx / IC);
         col_in       = CW'(idx % IC);
         disparity_in = pix(kind, idx / IC, idx % IC);
         for (int g = 1; g < gap; g++) begin
            @(negedge clk);
            en = 1'b0;
         end
      end
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic run_frame(input int kind, input int gap, input string tag);
      int base_v, base_d;
      base_v  = n_valid;
      base_d  = n_done;
      cur_gap = gap;
      send_span(kind, 0, 0, IR - 1, IC - 1, gap);
      repeat (8) @(negedge clk);
      check({tag, "_count"}, n_valid - base_v, N_OUT);
      check({tag, "_done"}, n_done - base_d, 1);
      cur_gap = 1;
   endtask

   initial begin
      int base_v;
      rst = 1'b0; en = 1'b0; row_in = '0; col_in = '0; disparity_in = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_data", disparity_out, 0);
      check("rst_row", row_out, 0);
      check("rst_col", col_out, 0);
      check("rst_done", frame_done, 0);
      rst = 1'b1;

      // Stream that starts mid-frame must be ignored until a frame start.
      base_v = n_valid;
      send_span(3, 7, 3, IR - 1, IC - 1, 1);
      repeat (8) @(negedge clk);
      check("midstart_count", n_valid - base_v, 0);

      run_frame(0, 1, "const");
      run_frame(1, 1, "outlier");
      run_frame(5, 1, "unsigned");
      run_frame(2, 13, "ramp");
      run_frame(3, 1, "rand");
      run_frame(4, 1, "bimodal");
      run_frame(6, 1, "ties");

      // Reset mid-frame with en high; the remainder of the frame must produce nothing.
      send_span(3, 0, 0, 6, 7, 1);
      @(negedge clk);
      en = 1'b1; row_in = CW'(6); col_in = CW'(8); disparity_in = $urandom;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      base_v = n_valid;
      send_span(3, 6, 9, IR - 1, IC - 1, 1);
      repeat (8) @(negedge clk);
      check("after_rst_count", n_valid - base_v, 0);
      run_frame(3, 1, "post_rst");

      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/disparity_median3x3.md
Name: disparity_median3x3

Overview:
- Streaming 3x3 median filter placed directly downstream of disparity_calc; consumes its (disparity, row_out, col_out, valid) stream.
- Removes isolated disparity outliers before results are written out.
- Uses two line buffers plus a 3x3 window, and a pipelined median-of-9 network.
- Emits interior pixels only; border fill is the writer's job.

Parameters:
- IMAGE_ROW, 200, rows per frame
- IMAGE_COL, 400, columns per frame (line buffer depth)
- DATA_W, 32, disparity word width (compared as unsigned)
- COORD_W, 10, row/col coordinate width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-low reset
- en  input  1  input pixel valid; may be high on consecutive cycles or sparse (e.g. 1-in-13)
- disparity_in  input  DATA_W  disparity of pixel (row_in, col_in)
- row_in  input  COORD_W  row of input pixel, raster order
- col_in  input  COORD_W  column of input pixel, raster order
- disparity_out  output  DATA_W  median of 3x3 window centred at (row_out, col_out)
- row_out  output  COORD_W  centre row
- col_out  output  COORD_W  centre column
- valid  output  1  one-cycle pulse per output pixel
- frame_done  output  1  one-cycle pulse, coincident with valid for centre (IMAGE_ROW-2, IMAGE_COL-2)

Behaviour:
- Reset (rst==0 at a clock edge): all outputs 0; pipeline valid bits, window registers and state cleared. Line buffer contents are not cleared.
- FSM states:
  - WAIT_SOF (reset state): ignores en unless row_in==0 and col_in==0; on that pixel go to RUN and accept it.
  - RUN: accept every en pixel. If the accepted pixel is (IMAGE_ROW-1, IMAGE_COL-1), return to WAIT_SOF after accepting it.
- Effect of WAIT_SOF: a reset mid-frame discards the rest of that frame, so no output is ever built from stale lines.
- Accept cycle for pixel (r,c):
  - Read-before-write at address c: lb1[c] is row r-1, lb0[c] is row r-2.
  - Write lb1[c] <= disparity_in and lb0[c] <= old lb1[c].
  - Shift window left; new right column = {lb0[c], lb1[c], disparity_in}.
- Emission: only when r>=2 and c>=2. Centre is (r-1, c-1). Outputs per frame = (IMAGE_ROW-2)*(IMAGE_COL-2) = 198*398 = 78804 at defaults.
- Window at c==0 and c==1 is filled but produces no output, so the row wrap needs no special clearing.
- Median network, fixed pipeline:
  - S1: sort each window row (3-sort).
  - S2: max of row minima, median of row medians, min of row maxima.
  - S3: median of those three.
- Latency: valid rises exactly 4 clock cycles after the sampling edge of the accepted en pixel. Throughput is 1 pixel/cycle.
- disparity_out, row_out and col_out hold their value until the next valid.
- Ties and equal values are fine; the result is an exact median of 9 unsigned words, with no saturation or rounding.
- Simultaneous events:
  - rst low with en high: reset wins, pixel dropped.
  - Reset never flushes a partially filled window to the output.
- en while in WAIT_SOF at a non-(0,0) coordinate: ignored, no state change.

Decomposition:
- Shared package sgbm_pkg holds the IMAGE_ROW/IMAGE_COL defaults, COORD_W and DATA_W, shared with disparity_calc.
- One natural sub-module: median3_sort. It is a combinational 3-input sorter producing min/med/max, instanced 3x in S1 and reused in S2/S3.
- Line buffers are inferred RAM inside the top block.

Test Plan:
- Constant frame, all pixels 0x00000005, en every cycle: 78804 valid pulses, all disparity_out=5. First output is (1,1), 4 cycles after pixel (2,2) is sampled. frame_done accompanies (198,398).
- Single outlier: a field of 0x10 with pixel (50,60)=0xFFFFFFFF: output at centre (50,60) is 0x10, as are all its neighbours.
- Ramp: value = row*IMAGE_COL+col, en 1-in-13 cycles: each output equals the centre value (r*400+c). Spacing between valid pulses is 13 cycles.
- Reset mid-frame: rst low for 3 cycles at pixel (100,200), then stream resumes at (100,201):
  - No valid until the next (0,0).
  - The next frame produces the full 78804 correct outputs.
- Unsigned compare check: window {0x80000000 x5, 0x00000001 x4} -> 0x80000000.
- Stream starting mid-frame at (7,3) after reset: zero outputs until (0,0) is seen.
